// File: rtl/cl_msg_serializer.sv
// rtl/cl_msg_serializer.sv - 128b capture message to 32b word serializer with capture trailer
//
// Pops 128b messages from a first-word-fall-through capture FIFO and writes
// them to the PC FIFO as four 32b words, most significant word first.
// A cl_done pulse queues one trailer word {TRAILER_TAG, message count}; it is
// written once the capture FIFO has drained.
//
// Ports
//   bus_clk    in   single clock
//   reset_n    in   synchronous reset, active low
//   in_data    in   head of the capture FIFO (FWFT)
//   in_empty   in   capture FIFO empty
//   in_rd_en   out  pop strobe to the capture FIFO
//   cl_done    in   one-cycle pulse, capture finished
//   out_data   out  word written to the PC FIFO
//   out_wr_en  out  write strobe to the PC FIFO
//   out_full   in   PC FIFO full
//   busy       out  serializer active or trailer pending
//   n_msg      out  messages popped since the last trailer
module cl_msg_serializer #(
   parameter logic [15:0] TRAILER_TAG = 16'hEEEE,
   parameter int          CNT_W       = 16
) (
   input  logic             bus_clk,
   input  logic             reset_n,
   input  logic [127:0]     in_data,
   input  logic             in_empty,
   output logic             in_rd_en,
   input  logic             cl_done,
   output logic [31:0]      out_data,
   output logic             out_wr_en,
   input  logic             out_full,
   output logic             busy,
   output logic [CNT_W-1:0] n_msg
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND    = 2'd1;
   localparam logic [1:0] ST_TRAILER = 2'd2;

   logic [1:0]       state;
   logic [1:0]       idx;
   logic [127:0]     shreg;
   logic             done_pend;
   logic [CNT_W-1:0] msg_cnt;

   logic             pop;
   logic             wr;
   logic             trailer_wr;
   logic [15:0]      cnt_ext;

   // Outputs are qualified with reset_n so nothing is popped or written
   // while reset is held, even though the FIFO may already hold data.
   // The pop at idx==0 in SEND lets the next message follow without a bubble.
   always_comb begin
      pop = reset_n && !in_empty &&
            ((state == ST_IDLE) ||
             (state == ST_SEND && idx == 2'd0 && !out_full));
   end

   always_comb begin
      wr = reset_n && !out_full &&
           (state == ST_SEND || state == ST_TRAILER);
   end

   always_comb begin
      trailer_wr = wr && (state == ST_TRAILER);
   end

   always_comb begin
      cnt_ext = '0;
      cnt_ext[CNT_W-1:0] = msg_cnt;
   end

   always_comb begin
      out_data = '0;
      if (reset_n) begin
         case (state)
            ST_SEND:    out_data = shreg[{idx, 5'b0} +: 32];
            ST_TRAILER: out_data = {TRAILER_TAG, cnt_ext};
            default:    out_data = '0;
         endcase
      end
   end

   assign in_rd_en  = pop;
   assign out_wr_en = wr;
   assign busy      = reset_n && ((state != ST_IDLE) || done_pend);
   assign n_msg     = msg_cnt;

   always_ff @(posedge bus_clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         idx       <= 2'd3;
         shreg     <= '0;
         done_pend <= 1'b0;
         msg_cnt   <= '0;
      end else begin
         // A pulse coinciding with the trailer write survives and produces
         // a second, zero-count trailer.
         done_pend <= cl_done || (done_pend && !trailer_wr);

         case (state)
            ST_IDLE: begin
               if (!in_empty) begin
                  state <= ST_SEND;
               end else if (done_pend) begin
                  state <= ST_TRAILER;
               end
            end
            ST_SEND: begin
               if (!out_full) begin
                  if (idx == 2'd0) begin
                     if (in_empty) begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     idx <= idx - 2'd1;
                  end
               end
            end
            ST_TRAILER: begin
               if (!out_full) begin
                  msg_cnt <= '0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Pops never happen in TRAILER, so this never collides with the clear.
         if (pop) begin
            shreg <= in_data;
            idx   <= 2'd3;
            if (msg_cnt != {CNT_W{1'b1}}) begin
               msg_cnt <= msg_cnt + 1'b1;
            end
         end
      end
   end

endmodule
